// File: rtl/mdu_ex.sv
// Multi-cycle multiply/divide unit for the EX stage: owns HI/LO, runs
// MULT/MULTU/DIV/DIVU over a fixed cycle count, and serves MTHI/MTLO/MFHI/MFLO.
module mdu_ex #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] mdOut,
  output logic [31:0] hiOut,
  output logic [31:0] loOut
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [31:0]     hi, lo;
  logic [31:0]     a_q, b_q;
  logic [3:0]      op_q;
  logic            launch, finish;
  logic            is_arith, is_mult_in;

  assign is_mult_in = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
  assign is_arith   = is_mult_in || (mdOp == OP_DIV) || (mdOp == OP_DIVU);

  // Arithmetic operates on the latched operands only.
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, div_n, div_d, q_raw, r_raw, q_s, r_s;
  logic        sgn_div;

  assign prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u  = {32'b0, a_q} * {32'b0, b_q};
  assign sgn_div = (op_q == OP_DIV);
  assign a_mag   = a_q[31] ? (32'd0 - a_q) : a_q;
  assign b_mag   = b_q[31] ? (32'd0 - b_q) : b_q;
  assign div_n   = sgn_div ? a_mag : a_q;
  // Divisor forced to 1 when zero; the result is discarded in that case anyway.
  assign div_d   = (b_q == '0) ? 32'd1 : (sgn_div ? b_mag : b_q);
  assign q_raw   = div_n / div_d;
  assign r_raw   = div_n % div_d;
  // Magnitude division makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
  assign q_s     = (a_q[31] ^ b_q[31]) ? (32'd0 - q_raw) : q_raw;
  assign r_s     = a_q[31] ? (32'd0 - r_raw) : r_raw;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start && is_arith) begin
        launch     = 1'b1;
        state_next = RUN;
      end
      RUN: if (cnt == CW'(1)) begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else begin
      if (launch) begin
        a_q  <= srcA;
        b_q  <= srcB;
        op_q <= mdOp;
        cnt  <= is_mult_in ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (finish) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end

      if (finish) begin
        case (op_q)
          OP_MULT:  {hi, lo} <= prod_s;
          OP_MULTU: {hi, lo} <= prod_u;
          OP_DIV, OP_DIVU: if (b_q != '0) begin
            hi <= sgn_div ? r_s : r_raw;
            lo <= sgn_div ? q_s : q_raw;
          end
          default: ;
        endcase
      end else if (state == IDLE) begin
        if (mdOp == OP_MTHI) hi <= srcA;
        if (mdOp == OP_MTLO) lo <= srcA;
      end
    end
  end

  assign busy  = (state == RUN);
  assign hiOut = hi;
  assign loOut = lo;

  always_comb begin
    mdOut = '0;
    case (mdOp)
      OP_MFHI: mdOut = hi;
      OP_MFLO: mdOut = lo;
      default: mdOut = '0;
    endcase
  end

endmodule
